// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: WIDTH-cycle shift-add multiply and restoring divide.
// Define MUL_DIV_UNIT_DIV_EN to compile in the divider; otherwise divide ops complete at once.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dz_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  wrk_q, wrk_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              dz_q, dz_d;

  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    mul_sum;
  logic [2*WIDTH-1:0] prod;

  // Signed ops (00, 10) work on magnitudes; the sign is reapplied at completion.
  assign a_neg   = ~op_i[0] & a_i[WIDTH-1];
  assign b_neg   = ~op_i[0] & b_i[WIDTH-1];
  assign a_mag   = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag   = b_neg ? (~b_i + 1'b1) : b_i;
  assign mul_sum = {1'b0, acc_q} + ({1'b0, mcand_q} & {(WIDTH + 1){wrk_q[0]}});

`ifdef MUL_DIV_UNIT_DIV_EN
  logic              is_div_q, is_div_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_pend_q, dz_pend_d;
  logic [WIDTH:0]    shifted;
  logic              div_ge;
  logic [WIDTH-1:0]  div_sub;

  // Partial remainder never reaches the divisor, so the W-bit subtract is exact.
  assign shifted = {acc_q, wrk_q[WIDTH-1]};
  assign div_ge  = shifted >= {1'b0, mcand_q};
  assign div_sub = shifted[WIDTH-1:0] - mcand_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wrk_d   = wrk_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    prod    = '0;
`ifdef MUL_DIV_UNIT_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    dz_pend_d = dz_pend_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
`ifdef MUL_DIV_UNIT_DIV_EN
          state_d   = StRun;
          cnt_d     = '0;
          acc_d     = '0;
          wrk_d     = a_mag;
          mcand_d   = b_mag;
          neg_d     = a_neg ^ b_neg;
          is_div_d  = op_i[1];
          neg_rem_d = a_neg;
          dz_pend_d = op_i[1] & (b_i == '0);
`else
          if (op_i[1]) begin
            state_d = StDone;
            dz_d    = 1'b0;
          end else begin
            state_d = StRun;
            cnt_d   = '0;
            acc_d   = '0;
            wrk_d   = a_mag;
            mcand_d = b_mag;
            neg_d   = a_neg ^ b_neg;
          end
`endif
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
`ifdef MUL_DIV_UNIT_DIV_EN
        if (is_div_q) begin
          acc_d = div_ge ? div_sub : shifted[WIDTH-1:0];
          wrk_d = {wrk_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
        end
`else
        acc_d = mul_sum[WIDTH:1];
        wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
`endif
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
`ifdef MUL_DIV_UNIT_DIV_EN
          if (is_div_q) begin
            // Divide by zero naturally leaves |a| as remainder; re-signed it equals a.
            lo_d = dz_pend_q ? '1 : (neg_q ? (~wrk_d + 1'b1) : wrk_d);
            hi_d = neg_rem_q ? (~acc_d + 1'b1) : acc_d;
            dz_d = dz_pend_q;
          end else begin
            prod = neg_q ? (~{acc_d, wrk_d} + 1'b1) : {acc_d, wrk_d};
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
            dz_d = 1'b0;
          end
`else
          prod = neg_q ? (~{acc_d, wrk_d} + 1'b1) : {acc_d, wrk_d};
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
          dz_d = 1'b0;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      wrk_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wrk_q   <= wrk_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
`ifdef MUL_DIV_UNIT_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
`endif
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign dz_o   = dz_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, is the operand and HI/LO width; all behaviour below is specified for WIDTH=32.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  WIDTH  operand A (register-file rd1, rs); multiplicand or dividend.
REQ-007 b  input  WIDTH  operand B (register-file rd2, rt); multiplier or divisor.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 hi  output  WIDTH  HI result register: product upper half or remainder.
REQ-011 lo  output  WIDTH  LO result register: product lower half or quotient.
REQ-012 dz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 at a clock edge SHALL latch a, b and op, and SHALL enter RUN; start=0 keeps IDLE.
REQ-015 RUN SHALL last exactly WIDTH cycles, one shift-add (multiply) or shift-subtract restoring step (divide) per cycle, then enter DONE.
REQ-016 On the RUN-to-DONE edge, hi, lo and dz SHALL update together; done=1 for exactly the one DONE cycle, then IDLE.
REQ-017 Latency: start sampled at edge N gives busy=1 in cycles N+1..N+32, and done=1 in cycle N+33.
REQ-018 start in RUN or DONE SHALL be ignored; it is neither queued nor able to corrupt the latched operands.
REQ-019 Operand changes after the start edge SHALL NOT affect the result.
REQ-020 hi/lo SHALL hold their value between completions, including throughout RUN.
REQ-021 MULT/MULTU: {hi,lo} SHALL equal the full 64-bit two's-complement (MULT) or unsigned (MULTU) product.
REQ-022 DIV/DIVU: lo SHALL hold the quotient truncated toward zero; hi SHALL hold the remainder, whose sign follows the dividend for DIV.
REQ-023 Divisor 0: lo=32'hFFFFFFFF, hi=a, dz=1; the full WIDTH-cycle latency still applies.
REQ-024 DIV of 32'h80000000 by 32'hFFFFFFFF: lo=32'h80000000, hi=0, dz=0.
REQ-025 Signed operations SHALL run on magnitudes and conditionally negate the results; no extra cycles are allowed.
REQ-026 dz SHALL be 0 after every non-divide-by-zero completion.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, dz=0 and clear the internal operands, regardless of clock.
REQ-028 Reset during RUN SHALL abort the operation; no done pulse follows, and hi/lo stay 0.
REQ-029 The first start is accepted at the first rising edge at which rst=0.

Configuration
REQ-030 Macro MUL_DIV_UNIT_DIV_EN: when defined, the divide datapath and behaviour in REQ-022..024 SHALL be compiled in.
REQ-031 When MUL_DIV_UNIT_DIV_EN is undefined, no divider logic SHALL exist.
REQ-032 Without the macro, op 10/11 SHALL skip RUN (IDLE->DONE), pulse done in cycle N+1, leave hi/lo unchanged and set dz=0.
REQ-033 Multiply behaviour SHALL be identical with and without MUL_DIV_UNIT_DIV_EN.

Verification
REQ-034 MULT a=32'hFFFFFFFD (-3), b=7 -> done in cycle N+33; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-035 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; busy high exactly 32 cycles.
REQ-036 DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, dz=0.
REQ-037 DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=100, dz=1; a following MULTU 2x3 -> hi=0, lo=6, dz=0.
REQ-038 Start MULTU 5x5; pulse start with new operands in cycle N+10; assert rst in cycle N+20 -> no done pulse, hi=lo=0, busy=0 immediately.
REQ-039 Without MUL_DIV_UNIT_DIV_EN: DIVU 9/3 after MULTU 2x3 -> done in cycle N+1; hi=0 and lo=6 unchanged.
